glitch_sweep_ctrl: RTL
======================

# glitch_sweep_ctrl

Sequencer that drives the voltage-glitch engine through a two-dimensional (offset × width) parameter sweep. It snapshots a sweep configuration, then for every grid point:
- optionally holds the target in reset, then lets it settle;
- loads offset/width into the glitch engine and arms it for one attempt;
- waits for completion or timeout, then reports the attempt.

It sits between the host command decoder and the glitch engine, replacing manual per-attempt arming.

## Interface
Parameters:
- W, 32: width of offset/width values and of attempt_cnt.
- RESET_CYCLES, 100: target reset hold length, in cycles.
- SETTLE_CYCLES, 1000: cycles between target reset release and arm.
- TIMEOUT, 1000000: maximum cycles spent in WAIT_DONE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  cancel sweep from any state.
- off_start, off_stop, off_step  in  W each  offset range; inclusive bounds.
- wid_start, wid_stop, wid_step  in  W each  width range; inclusive bounds.
- gl_offset, gl_width  out  W each  values presented to the glitch engine.
- gl_arm  out  1  one-cycle arm pulse to the glitch engine.
- gl_done  in  1  one-cycle pulse from the engine when the attempt ends.
- target_reset_n  out  1  target reset, active-low.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle report pulse.
- result_offset, result_width  out  W each  point of the reported attempt.
- result_timeout  out  1  reported attempt timed out; qualified by result_valid.
- attempt_cnt  out  W  attempts completed in the current sweep.
- sweep_done  out  1  one-cycle pulse when the sweep completes.

## Operation
- States: IDLE, LOAD, RESET_TGT, SETTLE, ARM, WAIT_DONE, REPORT, STEP, DONE.
- IDLE:
  - start=1 → LOAD.
  - start is ignored in every other state.
- LOAD:
  - snapshot all six range inputs; they are not re-read during the sweep;
  - cur_off=off_start, cur_wid=wid_start; attempt_cnt=0;
  - if off_start>off_stop or wid_start>wid_stop → DONE (zero attempts); else → RESET_TGT.
- RESET_TGT: target_reset_n=0 for RESET_CYCLES cycles → SETTLE.
- SETTLE: target_reset_n=1 for SETTLE_CYCLES cycles → ARM.
- ARM:
  - gl_arm=1 for one cycle → WAIT_DONE;
  - gl_offset/gl_width equal cur_off/cur_wid from ARM through REPORT.
- WAIT_DONE:
  - gl_done → REPORT with timeout flag 0;
  - TIMEOUT cycles elapsed → REPORT with timeout flag 1;
  - gl_done in the expiry cycle wins (flag 0).
  - gl_done outside WAIT_DONE is ignored.
- REPORT: result_valid=1 for one cycle with cur_off, cur_wid and the timeout flag; attempt_cnt increments.
- STEP: width is the inner loop, offset the outer loop.
  - Compute the W+1-bit sum cur_wid+wid_step. If wid_step≠0 and sum≤wid_stop: cur_wid=sum → RESET_TGT.
  - Otherwise: cur_wid=wid_start and advance offset by the same rule. If offset advanced → RESET_TGT, else → DONE.
  - A step of 0 produces a single point in that dimension.
  - The W+1-bit sum guarantees no wrap-around past 2^W-1.
- DONE: sweep_done=1 for one cycle → IDLE. attempt_cnt holds its value until the next LOAD.
- abort:
  - from any non-IDLE state → IDLE on the next edge;
  - target_reset_n=1, gl_arm=0; no result_valid, no sweep_done;
  - abort beats start, gl_done and timeout in the same cycle.

## Timing
- Reset values:
  - state IDLE; busy=0; target_reset_n=1;
  - gl_arm=0, result_valid=0, sweep_done=0, result_timeout=0;
  - gl_offset, gl_width, result_offset, result_width, attempt_cnt = 0.
- All outputs are registered.
- start at edge N:
  - LOAD at N+1;
  - RESET_TGT entered at N+2, with target_reset_n low from N+2;
  - gl_arm high at cycle N+2+RESET_CYCLES+SETTLE_CYCLES.
- gl_done at edge M → result_valid at M+1 → STEP at M+2.
- Timeout: result_valid asserts TIMEOUT+1 cycles after the gl_arm cycle.
- Empty range (start>stop): sweep_done 2 cycles after start.
- Reset mid-sweep: immediate return to IDLE with all reset values applied.

## Configuration
- Macro GLITCH_SWEEP_TGT_RESET_EN.
- Defined: RESET_TGT behaves as above.
- Undefined:
  - RESET_TGT is removed; STEP and LOAD go directly to SETTLE;
  - target_reset_n is tied to 1; RESET_CYCLES is unused.

## Test plan
- Offset 10..30 step 10, width 1..2 step 1 → 6 reports in order (10,1) (10,2) (20,1) (20,2) (30,1) (30,2); attempt_cnt=6; exactly one sweep_done.
- off_step=0, wid_step=0, start=5/7 → exactly one gl_arm with offset 5, width 7; one report; sweep_done.
- off_start=20, off_stop=10 → no gl_arm, no result_valid; sweep_done 2 cycles after start.
- TIMEOUT=50, gl_done withheld → result_valid with result_timeout=1 exactly 51 cycles after gl_arm. Repeat with gl_done on the expiry cycle → result_timeout=0.
- abort during WAIT_DONE → IDLE next cycle, busy=0, target_reset_n=1; no result_valid or sweep_done afterwards, including when a gl_done follows.
- off_start=0xFFFFFFF0, off_stop=0xFFFFFFFF, off_step=0x10, wid single point → one attempt only, no wrap to offset 0.

Source files
------------

// File: rtl/glitch_sweep_if.sv
// Host sweep controls plus glitch-engine handshake for glitch_sweep_ctrl.
// slave is the sequencer's view; master is the host/engine side.
interface glitch_sweep_if #(
  parameter int W = 32
);
  logic         start;
  logic         abort;
  logic [W-1:0] off_start;
  logic [W-1:0] off_stop;
  logic [W-1:0] off_step;
  logic [W-1:0] wid_start;
  logic [W-1:0] wid_stop;
  logic [W-1:0] wid_step;
  logic [W-1:0] gl_offset;
  logic [W-1:0] gl_width;
  logic         gl_arm;
  logic         gl_done;
  logic         target_reset_n;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result_offset;
  logic [W-1:0] result_width;
  logic         result_timeout;
  logic [W-1:0] attempt_cnt;
  logic         sweep_done;

  modport master (
    output start, abort, off_start, off_stop, off_step,
           wid_start, wid_stop, wid_step, gl_done,
    input  gl_offset, gl_width, gl_arm, target_reset_n, busy,
           result_valid, result_offset, result_width, result_timeout,
           attempt_cnt, sweep_done
  );

  modport slave (
    input  start, abort, off_start, off_stop, off_step,
           wid_start, wid_stop, wid_step, gl_done,
    output gl_offset, gl_width, gl_arm, target_reset_n, busy,
           result_valid, result_offset, result_width, result_timeout,
           attempt_cnt, sweep_done
  );
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// Offset x width glitch sweep sequencer; all outputs registered from next state.
// Define GLITCH_SWEEP_TGT_RESET_EN to hold the target in reset before each attempt.
module glitch_sweep_ctrl #(
  parameter int W             = 32,
  parameter int RESET_CYCLES  = 100,
  parameter int SETTLE_CYCLES = 1000,
  parameter int TIMEOUT       = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  glitch_sweep_if.slave bus
);
  // One shared counter times reset hold, settle and the done timeout.
  localparam int PrepMax = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CntMax  = (PrepMax > TIMEOUT) ? PrepMax : TIMEOUT;
  localparam int CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

`ifdef GLITCH_SWEEP_TGT_RESET_EN
  typedef enum logic [3:0] {
    IDLE, LOAD, RESET_TGT, SETTLE, ARM, WAIT_DONE, REPORT, STEP, DONE
  } state_e;
  localparam logic [CntW-1:0] ResetLast = CntW'(RESET_CYCLES - 1);
  localparam state_e PrepState = RESET_TGT;
`else
  typedef enum logic [3:0] {
    IDLE, LOAD, SETTLE, ARM, WAIT_DONE, REPORT, STEP, DONE
  } state_e;
  localparam state_e PrepState = SETTLE;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    curOff_q, curOff_d, curWid_q, curWid_d;
  logic [W-1:0]    offStop_q, offStop_d, offStep_q, offStep_d;
  logic [W-1:0]    widStart_q, widStart_d, widStop_q, widStop_d, widStep_q, widStep_d;
  logic [W:0]      offSum, widSum;
  logic            timedOut;
  logic            busy_q, busy_d, glArm_q, glArm_d;
  logic            resValid_q, resValid_d, resTimeout_q, resTimeout_d;
  logic            sweepDone_q, sweepDone_d;
  logic [W-1:0]    glOffset_q, glOffset_d, glWidth_q, glWidth_d;
  logic [W-1:0]    resOffset_q, resOffset_d, resWidth_q, resWidth_d;
  logic [W-1:0]    attemptCnt_q, attemptCnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      curOff_q     <= '0;
      curWid_q     <= '0;
      offStop_q    <= '0;
      offStep_q    <= '0;
      widStart_q   <= '0;
      widStop_q    <= '0;
      widStep_q    <= '0;
      busy_q       <= 1'b0;
      glArm_q      <= 1'b0;
      resValid_q   <= 1'b0;
      resTimeout_q <= 1'b0;
      sweepDone_q  <= 1'b0;
      glOffset_q   <= '0;
      glWidth_q    <= '0;
      resOffset_q  <= '0;
      resWidth_q   <= '0;
      attemptCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      curOff_q     <= curOff_d;
      curWid_q     <= curWid_d;
      offStop_q    <= offStop_d;
      offStep_q    <= offStep_d;
      widStart_q   <= widStart_d;
      widStop_q    <= widStop_d;
      widStep_q    <= widStep_d;
      busy_q       <= busy_d;
      glArm_q      <= glArm_d;
      resValid_q   <= resValid_d;
      resTimeout_q <= resTimeout_d;
      sweepDone_q  <= sweepDone_d;
      glOffset_q   <= glOffset_d;
      glWidth_q    <= glWidth_d;
      resOffset_q  <= resOffset_d;
      resWidth_q   <= resWidth_d;
      attemptCnt_q <= attemptCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    curOff_d   = curOff_q;
    curWid_d   = curWid_q;
    offStop_d  = offStop_q;
    offStep_d  = offStep_q;
    widStart_d = widStart_q;
    widStop_d  = widStop_q;
    widStep_d  = widStep_q;
    timedOut   = 1'b0;
    // W+1-bit sums so a step can never wrap past the top of the range.
    offSum     = {1'b0, curOff_q} + {1'b0, offStep_q};
    widSum     = {1'b0, curWid_q} + {1'b0, widStep_q};

    case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: begin
        offStop_d  = bus.off_stop;
        offStep_d  = bus.off_step;
        widStart_d = bus.wid_start;
        widStop_d  = bus.wid_stop;
        widStep_d  = bus.wid_step;
        curOff_d   = bus.off_start;
        curWid_d   = bus.wid_start;
        if (bus.off_start > bus.off_stop || bus.wid_start > bus.wid_stop) state_d = DONE;
        else state_d = PrepState;
      end
`ifdef GLITCH_SWEEP_TGT_RESET_EN
      RESET_TGT: if (cnt_q == ResetLast) state_d = SETTLE;
`endif
      SETTLE: if (cnt_q == SettleLast) state_d = ARM;
      ARM: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.gl_done) begin
          state_d = REPORT;
        end else if (cnt_q == TimeoutLast) begin
          state_d  = REPORT;
          timedOut = 1'b1;
        end
      end
      REPORT: state_d = STEP;
      STEP: begin
        if (widStep_q != '0 && widSum <= {1'b0, widStop_q}) begin
          curWid_d = widSum[W-1:0];
          state_d  = PrepState;
        end else begin
          curWid_d = widStart_q;
          if (offStep_q != '0 && offSum <= {1'b0, offStop_q}) begin
            curOff_d = offSum[W-1:0];
            state_d  = PrepState;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort) state_d = IDLE;

    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
    else cnt_d = cnt_q + CntW'(1);

    busy_d       = (state_d != IDLE);
    glArm_d      = (state_d == ARM);
    resValid_d   = (state_d == REPORT);
    sweepDone_d  = (state_d == DONE);
    glOffset_d   = glOffset_q;
    glWidth_d    = glWidth_q;
    resOffset_d  = resOffset_q;
    resWidth_d   = resWidth_q;
    resTimeout_d = resTimeout_q;
    attemptCnt_d = attemptCnt_q;
    if (state_d == ARM) begin
      glOffset_d = curOff_q;
      glWidth_d  = curWid_q;
    end
    if (state_d == REPORT) begin
      resOffset_d  = curOff_q;
      resWidth_d   = curWid_q;
      resTimeout_d = timedOut;
      attemptCnt_d = attemptCnt_q + W'(1);
    end
    if (state_d == LOAD) attemptCnt_d = '0;
  end

`ifdef GLITCH_SWEEP_TGT_RESET_EN
  logic tgtRstN_q;
  logic tgtRstN_d;

  assign tgtRstN_d = (state_d != RESET_TGT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tgtRstN_q <= 1'b1;
    else        tgtRstN_q <= tgtRstN_d;
  end

  assign bus.target_reset_n = tgtRstN_q;
`else
  assign bus.target_reset_n = 1'b1;
`endif

  assign bus.busy           = busy_q;
  assign bus.gl_arm         = glArm_q;
  assign bus.gl_offset      = glOffset_q;
  assign bus.gl_width       = glWidth_q;
  assign bus.result_valid   = resValid_q;
  assign bus.result_offset  = resOffset_q;
  assign bus.result_width   = resWidth_q;
  assign bus.result_timeout = resTimeout_q;
  assign bus.attempt_cnt    = attemptCnt_q;
  assign bus.sweep_done     = sweepDone_q;
endmodule
